keypad_nav_encoder: RTL
=======================

# keypad_nav_encoder

Transmitting end of the `key_code`/`key_valid` keypad interface consumed by the calculator data parser.
- Turns five raw push-buttons into events: four directions move a cursor over a ROWS×COLS virtual keypad; centre emits the key under the cursor.
- Each button is synchronised and debounced; held direction buttons auto-repeat.
- Cursor position is exported so the OLED keypad view can highlight the selected key.

## Interface
Parameters:
- `ROWS`, 4, keypad rows (2..8)
- `COLS`, 5, keypad columns (2..8); ROWS×COLS ≤ 32
- `DEBOUNCE_CYCLES`, 100000, consecutive stable synchronised samples required to change a debounced level (≥2)
- `REPEAT_DELAY`, 50000000, cycles a direction must stay held after its press event before the first auto-repeat
- `REPEAT_RATE`, 10000000, cycles between subsequent auto-repeats

Ports:
- `clk` in 1: the single clock
- `reset` in 1: synchronous, active-low reset
- `btnU`, `btnD`, `btnL`, `btnR`, `btnC` in 1 each: raw asynchronous buttons, active-high
- `key_code` out 5: key index = row×COLS + col, held stable between pulses
- `key_valid` out 1: one-cycle pulse qualifying `key_code`
- `cursor_row` out 3: current cursor row
- `cursor_col` out 3: current cursor column

## Operation
- Per button: 2-FF synchroniser, then a stable-level counter.
  - The counter resets whenever the sync output equals the debounced level.
  - Otherwise it increments; when it reaches DEBOUNCE_CYCLES−1, the debounced level toggles and the counter clears.
- Press event: debounced rising edge. It lasts one cycle and is registered. Releases generate no events.
- Cursor moves by one step per direction event:
  - U decrements row, D increments row, L decrements col, R increments col.
  - Both axes wrap around: row 0 −U → ROWS−1; col COLS−1 +R → 0.
- Same-cycle events:
  - U and D cancel. L and R cancel.
  - A vertical and a horizontal event apply together (diagonal move).
- Centre event: `key_code` ← row×COLS + col using the pre-move cursor of that cycle, and `key_valid` pulses. Centre never auto-repeats.
- Auto-repeat FSM states: R_IDLE, R_DELAY, R_REPEAT.
  - Any direction press event latches that direction and goes to R_DELAY with the counter cleared. If several directions press in the same cycle, priority is U > D > L > R.
  - R_DELAY: count to REPEAT_DELAY−1, then issue a synthetic event for the latched direction and go to R_REPEAT with the counter cleared.
  - R_REPEAT: every REPEAT_RATE cycles, issue a synthetic event for the latched direction.
  - From any state, if the latched direction's debounced level is 0, go to R_IDLE.
  - A new direction press in R_DELAY or R_REPEAT re-latches and restarts R_DELAY.
  - A synthetic event coinciding with a real press of the opposite direction cancels per the rule above.
- Arithmetic: row and column use independent 3-bit registers. `key_code` is computed with 5-bit unsigned arithmetic and no overflow is possible.

## Timing
- Reset values (while `reset`=0 at a clock edge):
  - `key_code`=0, `key_valid`=0, `cursor_row`=0, `cursor_col`=0
  - all sync flops, debounced levels and counters 0
  - FSM in R_IDLE
- Reset mid-operation aborts any pending debounce or repeat.
- A button held across reset release is seen as a fresh press: exactly one event, DEBOUNCE_CYCLES+3 edges after release.
- Latency: raw high first sampled at edge 0 → debounced high at edge DEBOUNCE_CYCLES+1 → press event registered → `key_valid` high in the cycle after edge DEBOUNCE_CYCLES+3.
- Cursor outputs update on the same edge that `key_valid` would.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no event.
- No back-pressure: the consumer must accept one pulse per cycle. The minimum spacing between pulses is DEBOUNCE_CYCLES×2 cycles.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5.

- Reset, then `btnC` high for 10 cycles → single `key_valid` pulse 7 edges after `btnC` rose, `key_code`=0. Release → no further pulse.
- Pulse `btnR` 7 times with full debounce each, then `btnC` → col wraps 0→4→0→2, `key_code`=2.
- `btnU` once from row 0 then `btnC` → `cursor_row`=3, `key_code`=15. Then `btnD` and `btnU` asserted together → cursor unchanged.
- `btnC` glitch of 3 cycles → no `key_valid`, cursor unchanged.
- Hold `btnD` 60 cycles → moves at press, press+20, press+25, +30, … (9 moves total, row wraps). Release → FSM returns to R_IDLE, no further moves.
- Hold `btnL`, pull `reset` low for 1 cycle mid-R_REPEAT, keep `btnL` held → outputs 0 after the reset edge, then one move to col 4 at 7 edges after release.

Source files
------------

// File: rtl/keypad_nav_encoder.sv
// Five-button keypad navigator: debounced buttons move a cursor over a ROWS x COLS
// virtual keypad with direction auto-repeat; the centre button emits the key under the cursor.
//
// state    | meaning
// R_IDLE   | no direction being repeated
// R_DELAY  | latched direction held, waiting REPEAT_DELAY before first repeat
// R_REPEAT | latched direction still held, repeating every REPEAT_RATE cycles
module keypad_nav_encoder #(
   parameter int ROWS            = 4,
   parameter int COLS            = 5,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_RATE     = 10000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btnU,
   input  logic       btnD,
   input  logic       btnL,
   input  logic       btnR,
   input  logic       btnC,
   output logic [4:0] key_code,
   output logic       key_valid,
   output logic [2:0] cursor_row,
   output logic [2:0] cursor_col
);

   localparam int DW      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW      = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
   localparam logic [2:0]    ROW_LAST   = 3'(ROWS - 1);
   localparam logic [2:0]    COL_LAST   = 3'(COLS - 1);
   localparam logic [4:0]    COLS_W     = 5'(COLS);

   typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} rpt_state_t;

   // bit order: 0=U 1=D 2=L 3=R 4=C
   logic [4:0] raw;
   logic [4:0] s1_q, s1_d, s2_q, s2_d;
   logic [4:0] lvl_q, lvl_d, lvl_dly_q, lvl_dly_d, press_q, press_d;
   logic [DW-1:0] cnt_q [5];
   logic [DW-1:0] cnt_d [5];

   rpt_state_t    state_q, state_d;
   logic [1:0]    dir_q, dir_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic [3:0]    syn, evt;
   logic          dir_held;

   logic [2:0] row_q, row_d, col_q, col_d;
   logic [4:0] key_code_q, key_code_d;
   logic       key_valid_q, key_valid_d;

   assign raw = {btnC, btnR, btnL, btnD, btnU};

   always_comb begin
      s1_d      = raw;
      s2_d      = s1_q;
      lvl_d     = lvl_q;
      lvl_dly_d = lvl_q;
      press_d   = lvl_q & ~lvl_dly_q;
      for (int i = 0; i < 5; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s2_q[i] == lvl_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == DEB_LAST) begin
            lvl_d[i] = ~lvl_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + DW'(1);
         end
      end
   end

   // A synthetic event is produced even when a new press arrives the same cycle,
   // so an opposite-direction press can cancel it in the cursor logic.
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      rcnt_d   = rcnt_q;
      syn      = '0;
      dir_held = lvl_q[dir_q];
      case (state_q)
         R_DELAY: begin
            if (rcnt_q == DELAY_LAST) begin
               syn[dir_q] = 1'b1;
               state_d    = R_REPEAT;
               rcnt_d     = '0;
            end else begin
               rcnt_d = rcnt_q + RW'(1);
            end
         end
         R_REPEAT: begin
            if (rcnt_q == RATE_LAST) begin
               syn[dir_q] = 1'b1;
               rcnt_d     = '0;
            end else begin
               rcnt_d = rcnt_q + RW'(1);
            end
         end
         default: ;
      endcase
      if (!dir_held) begin
         state_d = R_IDLE;
         rcnt_d  = '0;
         syn     = '0;
      end
      if (|press_q[3:0]) begin
         state_d = R_DELAY;
         rcnt_d  = '0;
         if (press_q[0])      dir_d = 2'd0;
         else if (press_q[1]) dir_d = 2'd1;
         else if (press_q[2]) dir_d = 2'd2;
         else                 dir_d = 2'd3;
      end
   end

   always_comb begin
      evt   = press_q[3:0] | syn;
      row_d = row_q;
      col_d = col_q;
      if (evt[0] && !evt[1])      row_d = (row_q == 3'd0) ? ROW_LAST : row_q - 3'd1;
      else if (evt[1] && !evt[0]) row_d = (row_q == ROW_LAST) ? 3'd0 : row_q + 3'd1;
      if (evt[2] && !evt[3])      col_d = (col_q == 3'd0) ? COL_LAST : col_q - 3'd1;
      else if (evt[3] && !evt[2]) col_d = (col_q == COL_LAST) ? 3'd0 : col_q + 3'd1;
      key_valid_d = press_q[4];
      key_code_d  = key_code_q;
      if (press_q[4]) key_code_d = 5'(row_q) * COLS_W + 5'(col_q);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_q        <= '0;
         s2_q        <= '0;
         lvl_q       <= '0;
         lvl_dly_q   <= '0;
         press_q     <= '0;
         for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
         state_q     <= R_IDLE;
         dir_q       <= '0;
         rcnt_q      <= '0;
         row_q       <= '0;
         col_q       <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         lvl_q       <= lvl_d;
         lvl_dly_q   <= lvl_dly_d;
         press_q     <= press_d;
         for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
         state_q     <= state_d;
         dir_q       <= dir_d;
         rcnt_q      <= rcnt_d;
         row_q       <= row_d;
         col_q       <= col_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
      end
   end

   assign key_code   = key_code_q;
   assign key_valid  = key_valid_q;
   assign cursor_row = row_q;
   assign cursor_col = col_q;

endmodule
